// File: rtl/vibrate_alarm_latch.sv
// Debounce, sticky-latch and event counting for the eight ADS zero-crossing alarms.
// Each channel runs a tick-paced ON/OFF qualifier; qualified alarms set a host-cleared latch.
module vibrate_alarm_latch #(
  parameter int unsigned NCH       = 8,
  parameter int unsigned TICK_DIV  = 50000,
  parameter int unsigned ON_TICKS  = 4,
  parameter int unsigned OFF_TICKS = 8,
  parameter int unsigned EVT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   alarm_in,
  input  logic             clr_req,
  input  logic [NCH-1:0]   clr_mask,
  output logic             clr_ack,
  output logic [NCH-1:0]   alarm_stable,
  output logic [NCH-1:0]   alarm_latched,
  output logic             alarm_any,
  output logic             irq,
  output logic [EVT_W-1:0] event_cnt
);

  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned PC_W  = $clog2(NCH + 1);
  localparam int unsigned SUM_W = ((EVT_W > PC_W) ? EVT_W : PC_W) + 1;
  localparam int unsigned CNT_W = 8;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_TICKS);
  localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_TICKS);
  localparam bit               ON_ONE   = (ON_TICKS == 1);
  localparam bit               OFF_ONE  = (OFF_TICKS == 1);
  localparam logic [EVT_W-1:0] EVT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ON_WAIT  = 2'd1,
    ACTIVE   = 2'd2,
    OFF_WAIT = 2'd3
  } ch_state_e;

  logic [PRE_W-1:0] pre_cnt;
  logic             tick;
  logic [NCH-1:0]   alarm_in_q;

  ch_state_e        state     [NCH];
  ch_state_e        state_nxt [NCH];
  logic [CNT_W-1:0] cnt       [NCH];
  logic [CNT_W-1:0] cnt_nxt   [NCH];

  logic [NCH-1:0]   qual;
  logic [NCH-1:0]   stable_nxt;
  logic [NCH-1:0]   latched_nxt;
  logic [NCH-1:0]   clr_bits;
  logic [PC_W-1:0]  qual_pop;
  logic [SUM_W-1:0] evt_sum;
  logic [EVT_W-1:0] evt_nxt;

  assign tick = (pre_cnt == PRE_LAST);

  // Debounce tick prescaler
  always_ff @(posedge clk) begin
    if (rst)       pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else           pre_cnt <= pre_cnt + PRE_W'(1);
  end

  // Per-channel qualifier next state; a qualify is entry to ACTIVE from the on side only
  always_comb begin
    qual       = '0;
    stable_nxt = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      state_nxt[i] = state[i];
      cnt_nxt[i]   = cnt[i];
      if (tick) begin
        case (state[i])
          IDLE: begin
            if (alarm_in_q[i]) begin
              if (ON_ONE) begin
                state_nxt[i] = ACTIVE;
                cnt_nxt[i]   = '0;
                qual[i]      = 1'b1;
              end else begin
                state_nxt[i] = ON_WAIT;
                cnt_nxt[i]   = CNT_W'(1);
              end
            end
          end
          ON_WAIT: begin
            if (!alarm_in_q[i]) begin
              state_nxt[i] = IDLE;
              cnt_nxt[i]   = '0;
            end else if (cnt[i] + CNT_W'(1) == ON_LAST) begin
              state_nxt[i] = ACTIVE;
              cnt_nxt[i]   = '0;
              qual[i]      = 1'b1;
            end else begin
              cnt_nxt[i]   = cnt[i] + CNT_W'(1);
            end
          end
          ACTIVE: begin
            if (!alarm_in_q[i]) begin
              if (OFF_ONE) begin
                state_nxt[i] = IDLE;
                cnt_nxt[i]   = '0;
              end else begin
                state_nxt[i] = OFF_WAIT;
                cnt_nxt[i]   = CNT_W'(1);
              end
            end
          end
          OFF_WAIT: begin
            if (alarm_in_q[i]) begin
              state_nxt[i] = ACTIVE;
              cnt_nxt[i]   = '0;
            end else if (cnt[i] + CNT_W'(1) == OFF_LAST) begin
              state_nxt[i] = IDLE;
              cnt_nxt[i]   = '0;
            end else begin
              cnt_nxt[i]   = cnt[i] + CNT_W'(1);
            end
          end
          default: begin
            state_nxt[i] = IDLE;
            cnt_nxt[i]   = '0;
          end
        endcase
      end
      stable_nxt[i] = (state_nxt[i] == ACTIVE) || (state_nxt[i] == OFF_WAIT);
    end
  end

  // Latch update (set beats clear) and saturating event accumulation
  always_comb begin
    clr_bits    = clr_req ? clr_mask : '0;
    latched_nxt = (alarm_latched & ~clr_bits) | qual;
    qual_pop    = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      qual_pop = qual_pop + PC_W'(qual[i]);
    end
    evt_sum = SUM_W'(event_cnt) + SUM_W'(qual_pop);
    evt_nxt = (evt_sum > SUM_W'(EVT_MAX)) ? EVT_MAX : EVT_W'(evt_sum);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alarm_in_q    <= '0;
      alarm_stable  <= '0;
      alarm_latched <= '0;
      alarm_any     <= 1'b0;
      irq           <= 1'b0;
      event_cnt     <= '0;
      clr_ack       <= 1'b0;
      for (int i = 0; i < int'(NCH); i++) begin
        state[i] <= IDLE;
        cnt[i]   <= '0;
      end
    end else begin
      alarm_in_q    <= alarm_in;
      alarm_stable  <= stable_nxt;
      alarm_latched <= latched_nxt;
      alarm_any     <= |latched_nxt;
      irq           <= |(latched_nxt & ~alarm_latched);
      event_cnt     <= evt_nxt;
      clr_ack       <= clr_req;
      for (int i = 0; i < int'(NCH); i++) begin
        state[i] <= state_nxt[i];
        cnt[i]   <= cnt_nxt[i];
      end
    end
  end

endmodule
